// File: rtl/kvaz_access_seq.sv
// Ramdisk access sequencer: turns kvaz bus strobes into one arbiter request per access,
// waits for the decoded address and the arbiter ack, and holds read data for the bus driver.
module kvaz_access_seq #(
  parameter int ADDR_TIMEOUT = 15,
  parameter int ACK_TIMEOUT  = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        blk_n,
  input  logic        negedge_zpzu_n,
  input  logic        negedge_chtzu_n,
  input  logic        clean_chtzu_n,
  input  logic        addr_valid,
  input  logic [15:0] addr,
  input  logic [2:0]  page,
  input  logic [7:0]  data_i,
  output logic        req_write,
  output logic        req_read,
  output logic [18:0] req_addr,
  output logic [7:0]  req_data,
  input  logic        ack,
  input  logic [7:0]  ack_data,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        err_overrun,
  output logic        err_timeout
);

  localparam int MAX_TIMEOUT = (ADDR_TIMEOUT > ACK_TIMEOUT) ? ADDR_TIMEOUT : ACK_TIMEOUT;
  localparam int CNT_W       = $clog2(MAX_TIMEOUT + 1);
  // A wait state gives up on the cycle its counter holds TIMEOUT-1, i.e. after TIMEOUT wait cycles.
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT_ADDR, ISSUE, WAIT_ACK, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             kind_wr;
  logic             wr_stb;
  logic             rd_stb;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign wr_stb = negedge_zpzu_n & ~blk_n;
  assign rd_stb = negedge_chtzu_n & ~blk_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      kind_wr     <= 1'b0;
      req_write   <= 1'b0;
      req_read    <= 1'b0;
      req_addr    <= '0;
      req_data    <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      req_write   <= 1'b0;
      req_read    <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
      if (state != IDLE && (wr_stb || rd_stb))
        err_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (wr_stb || rd_stb) begin
            busy    <= 1'b1;
            kind_wr <= wr_stb;
            if (wr_stb)
              req_data <= data_i;
            // Write wins a same-cycle collision; the read strobe is reported as lost.
            if (wr_stb && rd_stb)
              err_overrun <= 1'b1;
            if (addr_valid) begin
              req_addr  <= {page, addr};
              req_write <= wr_stb;
              req_read  <= ~wr_stb;
              state     <= ISSUE;
            end else begin
              cnt   <= '0;
              state <= WAIT_ADDR;
            end
          end
        end

        WAIT_ADDR: begin
          if (addr_valid) begin
            req_addr  <= {page, addr};
            req_write <= kind_wr;
            req_read  <= ~kind_wr;
            state     <= ISSUE;
          end else if (cnt >= ADDR_LAST) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_ACK;
        end

        WAIT_ACK: begin
          if (ack) begin
            if (kind_wr) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              rd_data  <= ack_data;
              rd_valid <= 1'b1;
              state    <= HOLD;
            end
          end else if (cnt >= ACK_LAST) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        HOLD: begin
          // Release on end of MEMRD, or immediately if the ramdisk is deselected.
          if (clean_chtzu_n || blk_n) begin
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          rd_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kvaz_access_seq.sv
// Bench for kvaz_access_seq: directed scenarios plus randomized accesses checked
// against an event-time model of the access protocol.
module tb_kvaz_access_seq;

  localparam int ADDR_TIMEOUT = 15;
  localparam int ACK_TIMEOUT  = 63;

  logic        clk = 1'b0;
  logic        reset;
  logic        blk_n;
  logic        negedge_zpzu_n;
  logic        negedge_chtzu_n;
  logic        clean_chtzu_n;
  logic        addr_valid;
  logic [15:0] addr;
  logic [2:0]  page;
  logic [7:0]  data_i;
  logic        req_write;
  logic        req_read;
  logic [18:0] req_addr;
  logic [7:0]  req_data;
  logic        ack;
  logic [7:0]  ack_data;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        err_overrun;
  logic        err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  kvaz_access_seq #(.ADDR_TIMEOUT(ADDR_TIMEOUT), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .blk_n(blk_n),
    .negedge_zpzu_n(negedge_zpzu_n), .negedge_chtzu_n(negedge_chtzu_n),
    .clean_chtzu_n(clean_chtzu_n), .addr_valid(addr_valid), .addr(addr),
    .page(page), .data_i(data_i), .req_write(req_write), .req_read(req_read),
    .req_addr(req_addr), .req_data(req_data), .ack(ack), .ack_data(ack_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  // Outputs are observed 1 time unit after the edge; inputs are changed at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    blk_n           = 1'b0;
    negedge_zpzu_n  = 1'b0;
    negedge_chtzu_n = 1'b0;
    clean_chtzu_n   = 1'b1;
    addr_valid      = 1'b0;
    addr            = 16'h0;
    page            = 3'h0;
    data_i          = 8'h0;
    ack             = 1'b0;
    ack_data        = 8'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    data_i = 8'hFF; addr = 16'hFFFF; addr_valid = 1'b1; ack = 1'b1; ack_data = 8'hFF;
    tick(); tick();
    n_tests++;
    if ({busy, rd_valid, req_write, req_read, err_overrun, err_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {busy, rd_valid, req_write, req_read, err_overrun, err_timeout});
    end
    n_tests++;
    if (req_addr !== 19'h0 || req_data !== 8'h0 || rd_data !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h data=%h rd=%h expected all 0", req_addr, req_data, rd_data);
    end
    reset = 1'b0;
    idle_inputs();
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_deselect();
    blk_n = 1'b1; negedge_zpzu_n = 1'b1; negedge_chtzu_n = 1'b1; addr_valid = 1'b1;
    tick();
    idle_inputs();
    n_tests++;
    if ({busy, req_write, req_read, err_overrun} !== 4'b0) begin
      n_fail++;
      $display("FAIL deselect_strobe: got %b expected 0000", {busy, req_write, req_read, err_overrun});
    end
  endtask

  task automatic test_write();
    addr = 16'h1234; page = 3'd5; data_i = 8'hA5; addr_valid = 1'b1; negedge_zpzu_n = 1'b1;
    tick();
    idle_inputs();
    n_tests++;
    if ({req_write, req_read, busy} !== 3'b101 || req_addr !== 19'h51234 || req_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_req: got w=%b r=%b busy=%b addr=%h data=%h expected 1 0 1 51234 a5",
               req_write, req_read, busy, req_addr, req_data);
    end
    tick();
    n_tests++;
    if (req_write !== 1'b0) begin
      n_fail++;
      $display("FAIL write_req_pulse: got %b expected 0", req_write);
    end
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || req_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_done: got busy=%b rd_valid=%b data=%h expected 0 0 a5", busy, rd_valid, req_data);
    end
  endtask

  task automatic test_late_read();
    int bad;
    clean_chtzu_n = 1'b0; negedge_chtzu_n = 1'b1; data_i = 8'h77;
    tick();
    negedge_chtzu_n = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (req_read !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0 || req_read !== 1'b0) begin
      n_fail++;
      $display("FAIL late_read_wait: got %0d bad cycles expected 0", bad);
    end
    addr_valid = 1'b1; addr = 16'h8000; page = 3'd0;
    tick();
    addr_valid = 1'b0; addr = 16'hFFFF; page = 3'd7;
    n_tests++;
    if (req_read !== 1'b1 || req_write !== 1'b0 || req_addr !== 19'h08000) begin
      n_fail++;
      $display("FAIL late_read_req: got r=%b w=%b addr=%h expected 1 0 08000", req_read, req_write, req_addr);
    end
    tick();
    ack = 1'b1; ack_data = 8'h3C;
    tick();
    ack = 1'b0; ack_data = 8'h00;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (rd_valid !== 1'b1 || rd_data !== 8'h3C) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0 || req_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL late_read_hold: got %0d bad cycles req_data=%h expected 0 a5", bad, req_data);
    end
    clean_chtzu_n = 1'b1;
    tick();
    n_tests++;
    if (rd_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL late_read_release: got rd_valid=%b busy=%b expected 0 0", rd_valid, busy);
    end
  endtask

  task automatic test_addr_timeout();
    int early, reqs;
    negedge_chtzu_n = 1'b1;
    tick();
    negedge_chtzu_n = 1'b0;
    early = 0; reqs = 0;
    for (int i = 1; i < ADDR_TIMEOUT; i++) begin
      tick();
      if (err_timeout !== 1'b0 || busy !== 1'b1) early++;
      if (req_read !== 1'b0) reqs++;
    end
    tick();
    n_tests++;
    if (early != 0 || reqs != 0 || err_timeout !== 1'b1 || busy !== 1'b0 || req_read !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_timeout: got early=%0d reqs=%0d err=%b busy=%b expected 0 0 1 0",
               early, reqs, err_timeout, busy);
    end
    tick();
    n_tests++;
    if (err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_timeout_pulse: got %b expected 0", err_timeout);
    end
  endtask

  task automatic test_simultaneous();
    int ovr, rds;
    addr_valid = 1'b1; addr = 16'h0042; page = 3'd2; data_i = 8'h5A;
    negedge_zpzu_n = 1'b1; negedge_chtzu_n = 1'b1;
    tick();
    idle_inputs();
    n_tests++;
    if ({req_write, req_read, err_overrun} !== 3'b101 || req_data !== 8'h5A || req_addr !== 19'h20042) begin
      n_fail++;
      $display("FAIL simul_req: got w/r/ovr=%b data=%h addr=%h expected 101 5a 20042",
               {req_write, req_read, err_overrun}, req_data, req_addr);
    end
    ovr = 1; rds = 0;
    tick();
    ovr += int'(err_overrun); rds += int'(req_read);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ovr += int'(err_overrun); rds += int'(req_read);
    n_tests++;
    if (ovr != 1 || rds != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_once: got overruns=%0d reads=%0d busy=%b expected 1 0 0", ovr, rds, busy);
    end
  endtask

  task automatic test_overrun_ack_timeout();
    int cyc;
    addr_valid = 1'b1; addr = 16'hBEEF; page = 3'd3; data_i = 8'h11; negedge_zpzu_n = 1'b1;
    tick();
    idle_inputs();
    tick();
    negedge_zpzu_n = 1'b1; data_i = 8'h99; addr_valid = 1'b1; addr = 16'h0000;
    tick();
    idle_inputs();
    n_tests++;
    if (err_overrun !== 1'b1 || busy !== 1'b1 || req_data !== 8'h11 || req_addr !== 19'h3BEEF) begin
      n_fail++;
      $display("FAIL overrun: got ovr=%b busy=%b data=%h addr=%h expected 1 1 11 3beef",
               err_overrun, busy, req_data, req_addr);
    end
    // Edge 2 just passed; the ack window ends at edge 1+ACK_TIMEOUT after the request edge 0.
    cyc = 2;
    while (err_timeout !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc != 1 + ACK_TIMEOUT || busy !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_timeout: got edge=%0d busy=%b rd_valid=%b expected %0d 0 0",
               cyc, busy, rd_valid, 1 + ACK_TIMEOUT);
    end
  endtask

  task automatic test_reset_in_hold();
    clean_chtzu_n = 1'b0; addr_valid = 1'b1; addr = 16'h0101; negedge_chtzu_n = 1'b1;
    tick();
    negedge_chtzu_n = 1'b0; addr_valid = 1'b0;
    tick();
    ack = 1'b1; ack_data = 8'hC3;
    tick();
    ack = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL hold_entry: got rd_valid=%b rd_data=%h expected 1 c3", rd_valid, rd_data);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_reset: got rd_valid=%b busy=%b expected 0 0", rd_valid, busy);
    end
    ack = 1'b1; ack_data = 8'h5F;
    tick();
    ack = 1'b0;
    tick();
    n_tests++;
    if ({rd_valid, busy, req_read, req_write} !== 4'b0) begin
      n_fail++;
      $display("FAIL late_ack: got %b expected 0000", {rd_valid, busy, req_read, req_write});
    end
    idle_inputs();
  endtask

  // Model: an access is described by event edges computed from the protocol rules,
  // and each cycle's expected outputs follow from where that cycle lies between them.
  task automatic test_random();
    bit wr, s_wr, exit_clean, accepted, acked;
    int d, k, h, s, r, ack_edge, exit_edge, to_edge, end_edge;
    logic [15:0] a;
    logic [2:0]  p;
    logic [7:0]  di, ad;
    logic [5:0]  exp_v, act_v;
    bit drv_ack;
    for (int it = 0; it < 30; it++) begin
      wr = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 5) == 0) ? ADDR_TIMEOUT + 1 + $urandom_range(0, 2)
                                       : (($urandom_range(0, 4) == 0) ? ADDR_TIMEOUT : $urandom_range(0, 4));
      k  = ($urandom_range(0, 7) == 0) ? ACK_TIMEOUT + 1
                                       : (($urandom_range(0, 9) == 0) ? ACK_TIMEOUT : $urandom_range(1, 6));
      h  = $urandom_range(1, 4);
      exit_clean = 1'($urandom_range(0, 1));
      s_wr = 1'($urandom_range(0, 1));
      a  = 16'($urandom); p = 3'($urandom); di = 8'($urandom); ad = 8'($urandom);

      accepted  = (d <= ADDR_TIMEOUT);
      acked     = accepted && (k <= ACK_TIMEOUT);
      r         = d;
      ack_edge  = r + 1 + k;
      exit_edge = ack_edge + h;
      to_edge   = !accepted ? ADDR_TIMEOUT : (!acked ? r + 1 + ACK_TIMEOUT : -1);
      end_edge  = !accepted ? ADDR_TIMEOUT : (!acked ? r + 1 + ACK_TIMEOUT : (wr ? ack_edge : exit_edge));
      s         = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(1, end_edge - 1);

      for (int e = 0; e <= end_edge + 2; e++) begin
        negedge_zpzu_n  = (e == 0 && wr)  || (e == s && s_wr);
        negedge_chtzu_n = (e == 0 && !wr) || (e == s && !s_wr);
        addr_valid      = (e == d);
        addr            = addr_valid ? a : 16'($urandom);
        page            = addr_valid ? p : 3'($urandom);
        data_i          = (e == 0) ? di : 8'($urandom);
        drv_ack         = accepted && (e == ack_edge || e == r + 1 || e == ack_edge + 1);
        ack             = drv_ack;
        ack_data        = (e == ack_edge) ? ad : 8'($urandom);
        blk_n           = !wr && acked && !exit_clean && (e == exit_edge);
        clean_chtzu_n   = wr || (acked && exit_clean && e >= exit_edge) || (e > end_edge);
        tick();

        exp_v = {e < end_edge,
                 !wr && acked && e >= ack_edge && e < exit_edge,
                 accepted && e == r && wr,
                 accepted && e == r && !wr,
                 e == s,
                 e == to_edge};
        act_v = {busy, rd_valid, req_write, req_read, err_overrun, err_timeout};
        n_tests++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL rand_ctrl it=%0d edge=%0d: got busy/rdv/w/r/ovr/to=%b expected %b (wr=%0d d=%0d k=%0d)",
                   it, e, act_v, exp_v, wr, d, k);
        end
        if (accepted && e == r) begin
          n_tests++;
          if (req_addr !== {p, a} || (wr && req_data !== di)) begin
            n_fail++;
            $display("FAIL rand_capture it=%0d: got addr=%h data=%h expected %h %h",
                     it, req_addr, req_data, {p, a}, di);
          end
        end
        if (exp_v[4] && rd_data !== ad) begin
          n_tests++;
          n_fail++;
          $display("FAIL rand_rd_data it=%0d edge=%0d: got %h expected %h", it, e, rd_data, ad);
        end else if (exp_v[4]) begin
          n_tests++;
        end
      end
      idle_inputs();
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_deselect();
    test_write();
    test_late_read();
    test_addr_timeout();
    test_simultaneous();
    test_overrun_ack_timeout();
    test_reset_in_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
